// File: rtl/mult_n_bit_seq.sv
// Shift-add unsigned multiplier on a single N-bit adder, valid/ready on both sides.
// Define MULT_ZERO_SKIP_EN to bypass the add loop when either operand is zero.

module adder_n_bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o,
  output logic         carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

module mult_n_bit_seq #(
  parameter int N = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  input  logic           valid_i,
  output logic           ready_o,
  output logic [2*N-1:0] product_o,
  output logic           valid_o,
  input  logic           ready_i
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sum;
  logic          carry;
  logic          zero_op;

  adder_n_bit #(
    .N(N)
  ) u_add (
    .a_i    (hi_q),
    .b_i    (a_q),
    .sum_o  (sum),
    .carry_o(carry)
  );

  assign zero_op   = (a_i == '0) || (b_i == '0);
  assign product_o = {hi_q, lo_q};
  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (valid_i) begin
          a_d     = a_i;
          hi_d    = '0;
          lo_d    = b_i;
          cnt_d   = '0;
          state_d = CALC;
`ifdef MULT_ZERO_SKIP_EN
          if (zero_op) begin
            lo_d    = '0;
            state_d = DONE;
          end
`endif
        end
      end
      CALC: begin
        // carry lands in the MSB, so the 2N-bit product never overflows
        if (lo_q[0]) begin
          {hi_d, lo_d} = {carry, sum, lo_q[N-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[N-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

`ifndef MULT_ZERO_SKIP_EN
  logic unused_zero;
  assign unused_zero = zero_op;
`endif

endmodule

// File: tb/tb_mult_n_bit_seq.sv
// Randomized bench for mult_n_bit_seq (N=8 and N=4) against a cycle-level
// transaction model, plus directed literal checks.

module tb_mult_n_bit_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  a8 = '0, b8 = '0;
  logic        v8 = 1'b0, r8 = 1'b0;
  logic        ready8, valid8;
  logic [15:0] prod8;

  logic [3:0]  a4 = '0, b4 = '0;
  logic        v4 = 1'b0, r4 = 1'b0;
  logic        ready4, valid4;
  logic [7:0]  prod4;

  mult_n_bit_seq #(.N(8)) u8 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a8), .b_i(b8), .valid_i(v8),
    .ready_o(ready8), .product_o(prod8), .valid_o(valid8), .ready_i(r8)
  );

  mult_n_bit_seq #(.N(4)) u4 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a4), .b_i(b4), .valid_i(v4),
    .ready_o(ready4), .product_o(prod4), .valid_o(valid4), .ready_i(r4)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic        pend8 = 1'b0, pend4 = 1'b0;
  logic [15:0] exp8 = '0;
  logic [7:0]  exp4 = '0;
  int          due8 = 0, due4 = 0;
  int          ops8 = 0, ops4 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // edges from "seen requesting" to product visible
  function automatic int lat_of(input logic zero, input int n);
`ifdef MULT_ZERO_SKIP_EN
    if (zero) return 1;
`endif
    return 1 + n;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // transaction model: at most one op in flight, result a*b visible after latency
  always @(negedge clk) begin
    if (!rst_n) begin
      pend8 = 1'b0;
      pend4 = 1'b0;
    end else begin
      if (pend8 && cyc >= due8) begin
        chk("u8_valid", 32'(valid8), 1);
        chk("u8_ready", 32'(ready8), 0);
        chk("u8_prod", 32'(prod8), 32'(exp8));
      end else if (pend8) begin
        chk("u8_valid_busy", 32'(valid8), 0);
        chk("u8_ready_busy", 32'(ready8), 0);
      end else begin
        chk("u8_valid_idle", 32'(valid8), 0);
        chk("u8_ready_idle", 32'(ready8), 1);
      end
      if (!pend8 && v8) begin
        pend8 = 1'b1;
        exp8  = 16'(a8) * 16'(b8);
        due8  = cyc + lat_of(a8 == 0 || b8 == 0, 8);
      end else if (pend8 && cyc >= due8 && r8) begin
        pend8 = 1'b0;
        ops8++;
      end

      if (pend4 && cyc >= due4) begin
        chk("u4_valid", 32'(valid4), 1);
        chk("u4_ready", 32'(ready4), 0);
        chk("u4_prod", 32'(prod4), 32'(exp4));
      end else if (pend4) begin
        chk("u4_valid_busy", 32'(valid4), 0);
        chk("u4_ready_busy", 32'(ready4), 0);
      end else begin
        chk("u4_valid_idle", 32'(valid4), 0);
        chk("u4_ready_idle", 32'(ready4), 1);
      end
      if (!pend4 && v4) begin
        pend4 = 1'b1;
        exp4  = 8'(a4) * 8'(b4);
        due4  = cyc + lat_of(a4 == 0 || b4 == 0, 4);
      end else if (pend4 && cyc >= due4 && r4) begin
        pend4 = 1'b0;
        ops4++;
      end
    end
  end

  task automatic accept(input int s, input logic [7:0] a, input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    if (s == 8) begin a8 = a; b8 = b; v8 = 1'b1; end
    else begin a4 = a[3:0]; b4 = b[3:0]; v4 = 1'b1; end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((s == 8) ? ready8 : ready4) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (s == 8) v8 = 1'b0; else v4 = 1'b0;
  endtask

  task automatic wait_valid(input int s, output int lat, output logic [15:0] p);
    lat = 0;
    p = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((s == 8) ? valid8 : valid4) begin
        p = (s == 8) ? prod8 : 16'(prod4);
        return;
      end
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic release_out(input int s);
    @(posedge clk); #1;
    if (s == 8) r8 = 1'b1; else r4 = 1'b1;
    @(posedge clk); #1;
    if (s == 8) r8 = 1'b0; else r4 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] p;
    int idx;
    int ops_before;
    int budget;

    #3;
    chk("rst_ready", 32'(ready8), 1);
    chk("rst_valid", 32'(valid8), 0);
    chk("rst_prod", 32'(prod8), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 13 * 11
    accept(8, 8'h0D, 8'h0B);
    wait_valid(8, lat, p);
    chk("t1_lat", 32'(lat), 8);
    chk("t1_prod", 32'(p), 32'h008F);
    release_out(8);
    @(negedge clk);
    chk("t1_ready_back", 32'(ready8), 1);

    accept(8, 8'hFF, 8'hFF);
    wait_valid(8, lat, p);
    chk("t2_prod", 32'(p), 32'hFE01);
    release_out(8);

    // stall with new operands presented at the input
    accept(8, 8'h80, 8'h02);
    wait_valid(8, lat, p);
    chk("t3_prod", 32'(p), 32'h0100);
    @(posedge clk); #1;
    a8 = 8'h11; b8 = 8'h22; v8 = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t3_stall_valid", 32'(valid8), 1);
    chk("t3_stall_prod", 32'(prod8), 32'h0100);
    chk("t3_stall_ready", 32'(ready8), 0);
    @(posedge clk); #1 v8 = 1'b0;
    release_out(8);

    // asynchronous reset after 3 calc cycles
    accept(8, 8'h12, 8'h34);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_ready", 32'(ready8), 1);
    chk("t4_rst_valid", 32'(valid8), 0);
    chk("t4_rst_prod", 32'(prod8), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    accept(8, 8'h03, 8'h05);
    wait_valid(8, lat, p);
    chk("t4_prod", 32'(p), 32'h000F);
    release_out(8);

    accept(8, 8'h00, 8'h5A);
    wait_valid(8, lat, p);
    chk("t5_zero_prod", 32'(p), 0);
`ifdef MULT_ZERO_SKIP_EN
    chk("t5_zero_lat", 32'(lat <= 1), 1);
`else
    chk("t5_zero_lat", 32'(lat), 8);
`endif
    release_out(8);
    accept(8, 8'h01, 8'h01);
    wait_valid(8, lat, p);
    chk("t5_one_prod", 32'(p), 1);
    chk("t5_one_lat", 32'(lat), 8);
    release_out(8);

    accept(4, 8'h0F, 8'h0F);
    wait_valid(4, lat, p);
    chk("n4_max_prod", 32'(p), 32'h00E1);
    chk("n4_max_lat", 32'(lat), 4);
    release_out(4);

    // N=8: free-running random valid/ready with corner-biased operands
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #1;
      case ($urandom_range(0, 7))
        0: a8 = 8'h00;
        1: a8 = 8'hFF;
        default: a8 = 8'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: b8 = 8'h00;
        1: b8 = 8'hFF;
        default: b8 = 8'($urandom);
      endcase
      v8 = ($urandom_range(0, 3) != 0);
      r8 = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk); #1 v8 = 1'b0; r8 = 1'b1;
    repeat (20) @(posedge clk);
    #1 r8 = 1'b0;
    chk("u8_ops_enough", 32'(ops8 > 1000), 1);

    // N=4: every operand pair with random gaps and backpressure
    idx = 0;
    ops_before = ops4;
    budget = 0;
    while ((idx < 256 || pend4) && budget < 20000) begin
      @(posedge clk); #1;
      if (v4) idx++;
      r4 = ($urandom_range(0, 1) != 0);
      if (!pend4 && idx < 256 && $urandom_range(0, 2) != 0) begin
        a4 = 4'(idx >> 4);
        b4 = 4'(idx);
        v4 = 1'b1;
      end else begin
        v4 = 1'b0;
        a4 = 4'($urandom);
        b4 = 4'($urandom);
      end
      budget++;
    end
    v4 = 1'b0;
    r4 = 1'b0;
    chk("u4_all_pairs", 32'(ops4 - ops_before), 256);

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
